harris_corner_tracker: RTL and testbench
========================================

Name: harris_corner_tracker

Overview:
- Sits directly downstream of the 7x7 Harris corner-response stage and consumes its per-pixel signed 54-bit response stream, qualified by the same clk_en.
- Thresholds each response, masks the image border where the window is invalid, and emits a registered per-pixel corner flag with its coordinates.
- Accumulates per-frame corner count, coordinate sums and bounding box, then publishes them with a one-cycle frame_done pulse for the box-tracking logic.

Parameters:
H_ACTIVE, 640, pixels per line
V_ACTIVE, 480, lines per frame
BORDER, 3, pixels excluded on every edge (7x7 window half-width)
X_W, 10, x coordinate width
Y_W, 9, y coordinate width
CNT_W, 16, corner counter width

Ports:
clk  in  1  pixel clock
reset  in  1  asynchronous, active-low reset (0 = reset)
clk_en  in  1  pixel-valid strobe; same strobe that advances the Harris stage
sof  in  1  start of frame; sampled only with clk_en, marks the sample at (0,0)
harris_feature  in  54 signed  corner response for the current pixel
threshold  in  54 signed  corner decision threshold, quasi-static
corner_flag  out  1  registered: previous valid pixel was a corner
corner_x  out  X_W  x of the flagged pixel
corner_y  out  Y_W  y of the flagged pixel
frame_done  out  1  one-cycle pulse when frame results update
corner_count  out  CNT_W  corners in last completed frame, saturating
sum_x  out  X_W+CNT_W  sum of corner x in last frame, saturating
sum_y  out  Y_W+CNT_W  sum of corner y in last frame, saturating
x_min, x_max  out  X_W  bounding box of last frame
y_min, y_max  out  Y_W  bounding box of last frame
box_valid  out  1  last completed frame had at least one corner

Behaviour:
- Reset (reset=0, async): all outputs, counters and accumulators go to 0; the internal min trackers go to their all-ones sentinel; the position counter goes to (0,0).
- Position counters x,y:
  - advance only when clk_en=1; x wraps H_ACTIVE-1 -> 0 and increments y; y wraps V_ACTIVE-1 -> 0.
  - sof=1 with clk_en=1 forces the current sample's position to (0,0); the next sample is (1,0).
  - sof without clk_en is ignored.
- in_roi: BORDER <= x <= H_ACTIVE-1-BORDER and BORDER <= y <= V_ACTIVE-1-BORDER.
- hit = clk_en & in_roi & (harris_feature > threshold), signed strict compare; equality is not a corner.
- Per-pixel outputs, latency 1 cycle:
  - corner_flag <= hit every clock, so it is 0 on any cycle following clk_en=0.
  - corner_x/corner_y load the sample position on every clk_en cycle and hold otherwise.
- Accumulation on hit:
  - count += 1, saturating at 2^CNT_W-1; once count saturates, sums freeze.
  - sum_x += x and sum_y += y, each saturating at its all-ones value.
  - min/max trackers updated with x,y.
- End of frame: a clk_en sample at (H_ACTIVE-1, V_ACTIVE-1) is the last of the frame (BORDER excludes it from hits).
  - Next cycle: frame outputs latch the accumulated values, frame_done=1 for exactly one cycle, accumulators clear (min trackers back to all-ones).
- Empty frame (count=0): box_valid=0 and x_min/x_max/y_min/y_max published as 0; otherwise box_valid=1 and the tracker values are published.
- sof arriving when the position counter is not at (0,0): the partial frame is discarded.
  - Accumulators clear; no frame_done; frame outputs hold their previous values.
  - The sof sample itself is accumulated into the new frame if it is a hit (it cannot be, being in the border).
- clk_en=0: counters, accumulators and frame outputs hold.
- Reset mid-frame: everything clears; the first frame after reset is reported only after a full frame of samples.
- No back-pressure; the block accepts one sample per clk_en.

Test Plan:
- Reset, then one frame of harris_feature=0, threshold=0 -> corner_flag never 1; frame_done pulses once, 1 cycle after sample (639,479); count=0, box_valid=0, bbox=0.
- Frame with feature=100 at (10,20) and (50,5), threshold=99 -> corner_flag high the cycle after each, corner_x/corner_y correct; at frame end count=2, sum_x=60, sum_y=25, x_min=10, x_max=50, y_min=5, y_max=20, box_valid=1.
- feature=threshold=-5 at (10,10) -> no flag; feature=-4, threshold=-5 -> flag (signed compare).
- Huge features at (1,1), (639,240) and (320,477) -> all masked, count=0; (3,3) and (636,476) -> both counted.
- clk_en toggling 50% over the second scenario -> identical results; corner_flag never high on the cycle after clk_en=0.
- sof injected at (100,100) after 3 hits, then a clean frame with 1 hit -> no frame_done for the partial frame; the next frame_done reports count=1. Drive reset=0 mid-frame -> all outputs 0 immediately (async).

Source files
------------

// File: rtl/harris_corner_tracker.sv
// Thresholds the Harris corner response, masks the invalid window border and
// accumulates per-frame corner statistics (count, coordinate sums, bounding box).
module harris_corner_tracker #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int BORDER   = 3,
    parameter int X_W      = 10,
    parameter int Y_W      = 9,
    parameter int CNT_W    = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clk_en,
    input  logic                    sof,
    input  logic signed [53:0]      harris_feature,
    input  logic signed [53:0]      threshold,
    output logic                    corner_flag,
    output logic [X_W-1:0]          corner_x,
    output logic [Y_W-1:0]          corner_y,
    output logic                    frame_done,
    output logic [CNT_W-1:0]        corner_count,
    output logic [X_W+CNT_W-1:0]    sum_x,
    output logic [Y_W+CNT_W-1:0]    sum_y,
    output logic [X_W-1:0]          x_min,
    output logic [X_W-1:0]          x_max,
    output logic [Y_W-1:0]          y_min,
    output logic [Y_W-1:0]          y_max,
    output logic                    box_valid
);

    localparam int SX_W = X_W + CNT_W;
    localparam int SY_W = Y_W + CNT_W;
    localparam logic [X_W-1:0] X_LAST = X_W'(H_ACTIVE - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_ACTIVE - 1);
    localparam logic [X_W-1:0] X_LO   = X_W'(BORDER);
    localparam logic [X_W-1:0] X_HI   = X_W'(H_ACTIVE - 1 - BORDER);
    localparam logic [Y_W-1:0] Y_LO   = Y_W'(BORDER);
    localparam logic [Y_W-1:0] Y_HI   = Y_W'(V_ACTIVE - 1 - BORDER);

    logic [X_W-1:0]   x_pos, cur_x;
    logic [Y_W-1:0]   y_pos, cur_y;
    logic             restart, discard, in_roi, hit, last_sample, eof_pending, clear;
    logic [CNT_W-1:0] acc_count, base_count, nxt_count;
    logic [SX_W-1:0]  acc_sum_x, base_sum_x, nxt_sum_x;
    logic [SY_W-1:0]  acc_sum_y, base_sum_y, nxt_sum_y;
    logic [SX_W:0]    sum_x_ext;
    logic [SY_W:0]    sum_y_ext;
    logic [X_W-1:0]   acc_x_min, acc_x_max, base_x_min, base_x_max, nxt_x_min, nxt_x_max;
    logic [Y_W-1:0]   acc_y_min, acc_y_max, base_y_min, base_y_max, nxt_y_min, nxt_y_max;

    // An sof sample is always position (0,0); sof away from the origin drops the partial frame.
    always_comb begin
        restart     = clk_en & sof;
        cur_x       = restart ? '0 : x_pos;
        cur_y       = restart ? '0 : y_pos;
        discard     = restart & ((x_pos != '0) | (y_pos != '0));
        in_roi      = (cur_x >= X_LO) && (cur_x <= X_HI) && (cur_y >= Y_LO) && (cur_y <= Y_HI);
        hit         = clk_en & in_roi & (harris_feature > threshold);
        last_sample = clk_en & (cur_x == X_LAST) & (cur_y == Y_LAST);
    end

    // Clearing and accumulating can coincide, so the current hit lands on a cleared base.
    always_comb begin
        clear      = eof_pending | discard;
        base_count = clear ? '0 : acc_count;
        base_sum_x = clear ? '0 : acc_sum_x;
        base_sum_y = clear ? '0 : acc_sum_y;
        base_x_min = clear ? '1 : acc_x_min;
        base_x_max = clear ? '0 : acc_x_max;
        base_y_min = clear ? '1 : acc_y_min;
        base_y_max = clear ? '0 : acc_y_max;
        sum_x_ext  = {1'b0, base_sum_x} + {{(CNT_W+1){1'b0}}, cur_x};
        sum_y_ext  = {1'b0, base_sum_y} + {{(CNT_W+1){1'b0}}, cur_y};
        nxt_count  = base_count;
        nxt_sum_x  = base_sum_x;
        nxt_sum_y  = base_sum_y;
        nxt_x_min  = base_x_min;
        nxt_x_max  = base_x_max;
        nxt_y_min  = base_y_min;
        nxt_y_max  = base_y_max;
        if (hit) begin
            if (base_count != '1) begin
                nxt_count = base_count + 1'b1;
                nxt_sum_x = sum_x_ext[SX_W] ? '1 : sum_x_ext[SX_W-1:0];
                nxt_sum_y = sum_y_ext[SY_W] ? '1 : sum_y_ext[SY_W-1:0];
            end
            if (cur_x < base_x_min) nxt_x_min = cur_x;
            if (cur_x > base_x_max) nxt_x_max = cur_x;
            if (cur_y < base_y_min) nxt_y_min = cur_y;
            if (cur_y > base_y_max) nxt_y_max = cur_y;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x_pos        <= '0;
            y_pos        <= '0;
            corner_flag  <= 1'b0;
            corner_x     <= '0;
            corner_y     <= '0;
            eof_pending  <= 1'b0;
            frame_done   <= 1'b0;
            acc_count    <= '0;
            acc_sum_x    <= '0;
            acc_sum_y    <= '0;
            acc_x_min    <= '1;
            acc_x_max    <= '0;
            acc_y_min    <= '1;
            acc_y_max    <= '0;
            corner_count <= '0;
            sum_x        <= '0;
            sum_y        <= '0;
            x_min        <= '0;
            x_max        <= '0;
            y_min        <= '0;
            y_max        <= '0;
            box_valid    <= 1'b0;
        end else begin
            corner_flag <= hit;
            eof_pending <= last_sample;
            frame_done  <= eof_pending;
            if (clk_en) begin
                corner_x <= cur_x;
                corner_y <= cur_y;
                if (cur_x == X_LAST) begin
                    x_pos <= '0;
                    y_pos <= (cur_y == Y_LAST) ? '0 : cur_y + 1'b1;
                end else begin
                    x_pos <= cur_x + 1'b1;
                    y_pos <= cur_y;
                end
            end
            acc_count <= nxt_count;
            acc_sum_x <= nxt_sum_x;
            acc_sum_y <= nxt_sum_y;
            acc_x_min <= nxt_x_min;
            acc_x_max <= nxt_x_max;
            acc_y_min <= nxt_y_min;
            acc_y_max <= nxt_y_max;
            // An empty frame publishes a zero box rather than the min sentinels.
            if (eof_pending) begin
                corner_count <= acc_count;
                sum_x        <= acc_sum_x;
                sum_y        <= acc_sum_y;
                box_valid    <= (acc_count != '0);
                x_min        <= (acc_count != '0) ? acc_x_min : '0;
                x_max        <= (acc_count != '0) ? acc_x_max : '0;
                y_min        <= (acc_count != '0) ? acc_y_min : '0;
                y_max        <= (acc_count != '0) ? acc_y_max : '0;
            end
        end
    end

endmodule

// File: tb/tb_harris_corner_tracker.sv
// Directed bench for harris_corner_tracker on a reduced 64x48 frame; per-frame
// scenarios come from a vector table, discard and mid-frame reset are hand-written.
module tb_harris_corner_tracker;

    localparam int H = 64;
    localparam int V = 48;
    localparam int B = 3;
    localparam longint HUGE = 64'sd9007199254740991;

    typedef struct {
        string  name;
        longint base_f;
        longint thr;
        int     hx0, hy0;
        longint hf0;
        int     hx1, hy1;
        longint hf1;
        int     hx2, hy2;
        longint hf2;
        bit     toggle;
        int     e_count, e_sx, e_sy, e_xmin, e_xmax, e_ymin, e_ymax;
        bit     e_valid;
    } vec_t;

    logic               clk = 1'b0;
    logic               reset;
    logic               clk_en;
    logic               sof;
    logic signed [53:0] harris_feature;
    logic signed [53:0] threshold;
    logic               corner_flag;
    logic [9:0]         corner_x;
    logic [8:0]         corner_y;
    logic               frame_done;
    logic [15:0]        corner_count;
    logic [25:0]        sum_x;
    logic [24:0]        sum_y;
    logic [9:0]         x_min, x_max;
    logic [8:0]         y_min, y_max;
    logic               box_valid;

    int     checks = 0;
    int     errors = 0;
    vec_t   vecs[6];
    longint cur_base, cur_thr;
    int     cur_hx[3], cur_hy[3];
    longint cur_hf[3];
    bit     cur_toggle;

    harris_corner_tracker #(.H_ACTIVE(H), .V_ACTIVE(V), .BORDER(B),
                            .X_W(10), .Y_W(9), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .clk_en(clk_en), .sof(sof),
        .harris_feature(harris_feature), .threshold(threshold),
        .corner_flag(corner_flag), .corner_x(corner_x), .corner_y(corner_y),
        .frame_done(frame_done), .corner_count(corner_count),
        .sum_x(sum_x), .sum_y(sum_y), .x_min(x_min), .x_max(x_max),
        .y_min(y_min), .y_max(y_max), .box_valid(box_valid)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic longint featureAt(input int x, input int y);
        longint r = cur_base;
        for (int k = 0; k < 3; k++)
            if (cur_hx[k] == x && cur_hy[k] == y) r = cur_hf[k];
        return r;
    endfunction

    function automatic bit inRoi(input int x, input int y);
        return (x >= B) && (x <= H - 1 - B) && (y >= B) && (y <= V - 1 - B);
    endfunction

    task automatic loadVec(input vec_t v);
        cur_base   = v.base_f;
        cur_thr    = v.thr;
        cur_hx[0]  = v.hx0; cur_hy[0] = v.hy0; cur_hf[0] = v.hf0;
        cur_hx[1]  = v.hx1; cur_hy[1] = v.hy1; cur_hf[1] = v.hf1;
        cur_hx[2]  = v.hx2; cur_hy[2] = v.hy2; cur_hf[2] = v.hf2;
        cur_toggle = v.toggle;
    endtask

    // Idle cycles carry sof=1 and a huge feature; both must be ignored without clk_en.
    task automatic applyStimulus(input int x, input int y, input bit first, input bit last);
        longint f = featureAt(x, y);
        clk_en         = 1'b1;
        sof            = first;
        harris_feature = 54'(f);
        threshold      = 54'(cur_thr);
        @(posedge clk); #1;
        checkOutput("corner_flag", longint'(corner_flag), longint'(inRoi(x, y) && (f > cur_thr)));
        checkOutput("corner_x", longint'(corner_x), longint'(x));
        checkOutput("corner_y", longint'(corner_y), longint'(y));
        checkOutput("frame_done_quiet", longint'(frame_done), 0);
        if (cur_toggle && !last) begin
            clk_en         = 1'b0;
            sof            = 1'b1;
            harris_feature = 54'(HUGE);
            @(posedge clk); #1;
            checkOutput("flag_after_idle", longint'(corner_flag), 0);
            checkOutput("x_hold_idle", longint'(corner_x), longint'(x));
            sof = 1'b0;
        end
    endtask

    task automatic feed(input int npix);
        for (int i = 0; i < npix; i++)
            applyStimulus(i % H, i / H, i == 0, i == H * V - 1);
    endtask

    task automatic finishFrame(input vec_t v);
        clk_en = 1'b0;
        sof    = 1'b0;
        @(posedge clk); #1;
        checkOutput({v.name, ".frame_done"}, longint'(frame_done), 1);
        checkOutput({v.name, ".flag_low"}, longint'(corner_flag), 0);
        checkOutput({v.name, ".count"}, longint'(corner_count), longint'(v.e_count));
        checkOutput({v.name, ".sum_x"}, longint'(sum_x), longint'(v.e_sx));
        checkOutput({v.name, ".sum_y"}, longint'(sum_y), longint'(v.e_sy));
        checkOutput({v.name, ".x_min"}, longint'(x_min), longint'(v.e_xmin));
        checkOutput({v.name, ".x_max"}, longint'(x_max), longint'(v.e_xmax));
        checkOutput({v.name, ".y_min"}, longint'(y_min), longint'(v.e_ymin));
        checkOutput({v.name, ".y_max"}, longint'(y_max), longint'(v.e_ymax));
        checkOutput({v.name, ".box_valid"}, longint'(box_valid), longint'(v.e_valid));
        @(posedge clk); #1;
        checkOutput({v.name, ".done_one_cycle"}, longint'(frame_done), 0);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, ".corner_flag"}, longint'(corner_flag), 0);
        checkOutput({tag, ".corner_x"}, longint'(corner_x), 0);
        checkOutput({tag, ".corner_y"}, longint'(corner_y), 0);
        checkOutput({tag, ".frame_done"}, longint'(frame_done), 0);
        checkOutput({tag, ".count"}, longint'(corner_count), 0);
        checkOutput({tag, ".sum_x"}, longint'(sum_x), 0);
        checkOutput({tag, ".sum_y"}, longint'(sum_y), 0);
        checkOutput({tag, ".x_max"}, longint'(x_max), 0);
        checkOutput({tag, ".y_max"}, longint'(y_max), 0);
        checkOutput({tag, ".box_valid"}, longint'(box_valid), 0);
    endtask

    initial begin
        vec_t part, clean;
        vecs[0] = '{"zero",     0,    0,  -1,-1,0,     -1,-1,0,     -1,-1,0,     1'b0, 0,  0,  0,  0,  0,  0,  0, 1'b0};
        vecs[1] = '{"two_hits", 0,   99,  10,20,100,   50,5,100,    -1,-1,0,     1'b0, 2, 60, 25, 10, 50,  5, 20, 1'b1};
        vecs[2] = '{"signed", -100,  -5,  10,10,-5,    20,20,-4,    -1,-1,0,     1'b0, 1, 20, 20, 20, 20, 20, 20, 1'b1};
        vecs[3] = '{"masked",   0,    0,   1,1,HUGE,   63,24,HUGE,  32,45,HUGE,  1'b0, 0,  0,  0,  0,  0,  0,  0, 1'b0};
        vecs[4] = '{"edges",    0,    0,   3,3,HUGE,   60,44,HUGE,  -1,-1,0,     1'b0, 2, 63, 47,  3, 60,  3, 44, 1'b1};
        vecs[5] = '{"toggle",   0,   99,  10,20,100,   50,5,100,    -1,-1,0,     1'b1, 2, 60, 25, 10, 50,  5, 20, 1'b1};
        part    = '{"partial",  0,    0,  10,5,50,     20,6,50,     40,40,50,    1'b0, 0,  0,  0,  0,  0,  0,  0, 1'b0};
        clean   = '{"clean",    0,    0,  30,30,50,    -1,-1,0,     -1,-1,0,     1'b0, 1, 30, 30, 30, 30, 30, 30, 1'b1};

        reset = 1'b0; clk_en = 1'b0; sof = 1'b0; harris_feature = '0; threshold = '0;
        #12;
        checkAllZero("reset");
        @(negedge clk) reset = 1'b1;

        for (int i = 0; i < 6; i++) begin
            $display("[TB] scenario %s", vecs[i].name);
            loadVec(vecs[i]);
            feed(H * V);
            finishFrame(vecs[i]);
        end

        $display("[TB] sof discard of a partial frame");
        loadVec(part);
        feed(40 * H + 41);
        loadVec(clean);
        feed(H * V);
        checkOutput("discard.count_held", longint'(corner_count), 2);
        checkOutput("discard.sum_x_held", longint'(sum_x), 60);
        finishFrame(clean);

        $display("[TB] asynchronous reset mid-frame");
        loadVec(part);
        feed(40 * H + 41);
        #2 reset = 1'b0;
        #1;
        checkAllZero("midreset");
        @(negedge clk) reset = 1'b1;
        loadVec(vecs[1]);
        feed(H * V);
        finishFrame(vecs[1]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
